// File: rtl/adder_arb.sv
// adder_arb: two-requester round-robin front end to a single registered
// (W+1)-bit adder. One transaction is in flight at a time:
// IDLE (grant) -> EXEC (add) -> RESP (hold until rsp_ready).
module adder_arb #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [W:0]   rsp_sum,
  output logic         rsp_id,
  input  logic         rsp_ready,
  output logic         busy,
  output logic [7:0]   done0_cnt,
  output logic [7:0]   done1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         id_q, id_d;
  logic [W:0]   sum_q, sum_d;
  logic         last_q, last_d;
  logic [7:0]   cnt0_q, cnt0_d;
  logic [7:0]   cnt1_q, cnt1_d;

  logic         grant_any;
  logic         grant_id;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state, datapath load and handshake outputs.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    sum_d      = sum_q;
    last_d     = last_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a : req0_a;
          b_d        = grant_id ? req1_b : req0_b;
          id_d       = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
          if (id_q) begin
            cnt1_d = cnt1_q + 8'd1;
          end else begin
            cnt0_d = cnt0_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign done0_cnt = cnt0_q;
  assign done1_cnt = cnt1_q;

endmodule

// File: tb/tb_adder_arb.sv
// Bench for adder_arb: transaction-level reference model checked every cycle,
// a vector table, hand-written corner sequences and randomized traffic.
module tb_adder_arb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req1_ready;
  logic         rsp_valid;
  logic [W:0]   rsp_sum;
  logic         rsp_id;
  logic         rsp_ready = 1'b0;
  logic         busy;
  logic [7:0]   done0_cnt;
  logic [7:0]   done1_cnt;

  adder_arb #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .done0_cnt  (done0_cnt),
    .done1_cnt  (done1_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one transaction in flight, tracked by edges since its handshake.
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_id   = 0;
  int m_sum  = 0;
  int m_last = 1;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  // Values sampled at the most recent negedge.
  bit s_rdy0 = 1'b0;
  bit s_rdy1 = 1'b0;
  bit s_rv   = 1'b0;
  int s_id   = 0;
  int s_sum  = 0;

  typedef struct {
    int v0; int a0; int b0;
    int v1; int a1; int b1;
    int exp_id; int exp_sum;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: -1 = nobody, else granted requester.
  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock: check at negedge, advance the model at posedge, return at posedge+1.
  task automatic cycle();
    int g;
    @(negedge clk);
    s_rdy0 = req0_ready;
    s_rdy1 = req1_ready;
    s_rv   = rsp_valid;
    s_id   = int'(rsp_id);
    s_sum  = int'(rsp_sum);
    g = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
    chk("req0_ready", int'(req0_ready), int'(g == 0));
    chk("req1_ready", int'(req1_ready), int'(g == 1));
    chk("busy", int'(busy), int'(m_busy));
    chk("rsp_valid", int'(rsp_valid), int'(m_busy && m_age >= 1));
    if (m_busy && m_age >= 1) begin
      chk("rsp_sum", int'(rsp_sum), m_sum);
      chk("rsp_id", int'(rsp_id), m_id);
    end
    chk("done0_cnt", int'(done0_cnt), m_cnt0);
    chk("done1_cnt", int'(done1_cnt), m_cnt1);
    @(posedge clk);
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = g;
        m_sum  = (g == 0) ? int'(req0_a) + int'(req0_b) : int'(req1_a) + int'(req1_b);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rsp_ready) begin
      if (m_id == 0) m_cnt0 = (m_cnt0 + 1) % 256;
      else           m_cnt1 = (m_cnt1 + 1) % 256;
      m_last = m_id;
      m_busy = 1'b0;
    end
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_sum", int'(rsp_sum), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_done0", int'(done0_cnt), 0);
    chk("rst_done1", int'(done1_cnt), 0);
    m_busy = 1'b0; m_age = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Run until rsp_valid is seen; n = cycles taken, 99 if it never came.
  task automatic wait_rsp(output int n);
    bit seen;
    seen = 1'b0;
    n = 99;
    for (int c = 1; c <= 8 && !seen; c++) begin
      cycle();
      if (s_rv) begin
        seen = 1'b1;
        n = c;
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hs;
    int ids[4];

    tbl[0] = '{1, 3, 4, 0, 0, 0, 0, 7};
    tbl[1] = '{0, 0, 0, 1, 10, 10, 1, 20};
    tbl[2] = '{1, 15, 15, 0, 0, 0, 0, 30};
    tbl[3] = '{1, 1, 2, 1, 5, 6, 1, 11};
    tbl[4] = '{1, 7, 8, 1, 0, 0, 0, 15};
    tbl[5] = '{0, 0, 0, 1, 15, 0, 1, 15};
    tbl[6] = '{1, 0, 0, 1, 9, 9, 0, 0};

    @(posedge clk);
    #1;

    // Vector table, single transactions with rsp_ready held high.
    do_reset();
    rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0[0];
      req0_a     = tbl[i].a0[W-1:0];
      req0_b     = tbl[i].b0[W-1:0];
      req1_valid = tbl[i].v1[0];
      req1_a     = tbl[i].a1[W-1:0];
      req1_b     = tbl[i].b1[W-1:0];
      hs = 1'b0;
      for (int c = 0; c < 4 && !hs; c++) begin
        cycle();
        hs = s_rdy0 | s_rdy1;
      end
      chk("tbl_handshake", int'(hs), 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(n);
      chk("tbl_latency", n, 2);
      chk("tbl_id", s_id, tbl[i].exp_id);
      chk("tbl_sum", s_sum, tbl[i].exp_sum);
    end
    chk("tbl_done0", int'(done0_cnt), 4);
    chk("tbl_done1", int'(done1_cnt), 3);

    // Contention straight after reset: grants alternate starting with requester 0.
    do_reset();
    rsp_ready = 1'b1;
    req0_a = 4'd5;  req0_b = 4'd9;
    req1_a = 4'd12; req1_b = 4'd3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      ids[k] = s_id;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();
    chk("rr_id0", ids[0], 0);
    chk("rr_id1", ids[1], 1);
    chk("rr_id2", ids[2], 0);
    chk("rr_id3", ids[3], 1);
    chk("rr_done0", int'(done0_cnt), 2);
    chk("rr_done1", int'(done1_cnt), 2);

    // Backpressure: response held while requester 1 waits and is ignored.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd8;
    cycle();
    chk("bp_handshake", int'(s_rdy0), 1);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    wait_rsp(n);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_sum", s_sum, 17);
      chk("bp_id", s_id, 0);
      chk("bp_ready1", int'(s_rdy1), 0);
      chk("bp_busy", int'(busy), 1);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_done0", int'(done0_cnt), 1);
    chk("bp_busy_after", int'(busy), 0);
    cycle();
    chk("bp_req1_granted", int'(s_rdy1), 1);
    req1_valid = 1'b0;
    wait_rsp(n);
    cycle();
    chk("bp_done1", int'(done1_cnt), 1);

    // Reset during EXEC aborts the transaction.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    cycle();
    chk("mid_handshake", int'(s_rdy0), 1);
    req0_valid = 1'b0;
    chk("mid_busy_exec", int'(busy), 1);
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
    chk("mid_done0", int'(done0_cnt), 0);

    // 256 completions on requester 0 wrap its counter back to zero.
    do_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 256; t++) begin
      req0_valid = 1'b1;
      req0_a = W'($urandom);
      req0_b = W'($urandom);
      cycle();
      req0_valid = 1'b0;
      wait_rsp(n);
    end
    cycle();
    chk("wrap_done0", int'(done0_cnt), 0);
    chk("wrap_done1", int'(done1_cnt), 0);

    // Randomized traffic; requesters hold valid and operands until granted.
    do_reset();
    s_rdy0 = 1'b0;
    s_rdy1 = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!req0_valid || s_rdy0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = W'($urandom);
        req0_b = W'($urandom);
      end
      if (!req1_valid || s_rdy1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = W'($urandom);
        req1_b = W'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
